cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the CPU's instruction-fetch requester and data (load/store) requester.
- Each side uses an sram-like handshake: req, then addr_ok, then data_ok.
- Sits between the IF/EXE/MEM stages and the single bus bridge. At most one transaction is outstanding.
- Data has priority over instruction, with a starvation guard for instruction fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants while inst_req is pending, after which inst wins the next contested grant. Range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction request valid.
- inst_wr  in  1  write flag; inst side drives 0.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte write strobes.
- inst_addr  in  ADDR_W  request address.
- inst_wdata  in  DATA_W  write data.
- inst_addr_ok  out  1  inst request accepted.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  DATA_W  read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  same widths as inst_*  data-side request.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response valid.
- data_rdata  out  DATA_W  read data.
- mem_req  out  1  downstream request valid.
- mem_wr  out  1  downstream write flag.
- mem_size  out  2  downstream size.
- mem_wstrb  out  4  downstream byte strobes.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_addr_ok  in  1  downstream accepted mem_req.
- mem_data_ok  in  1  downstream response or write-done.
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- FSM states: IDLE, REQ, RESP. Async reset forces IDLE, clears latched request registers, owner and starvation counter.
- Reset values: every registered output is 0. inst_rdata/data_rdata are combinational copies of mem_rdata and are meaningful only with the matching data_ok.
- Reset mid-transaction drops the in-flight transaction silently; the bus bridge is reset by the same signal.
- IDLE: arbitrate combinationally.
  - data_req only: data wins.
  - inst_req only: inst wins.
  - Both: data wins unless starve_cnt == STARVE_LIMIT, then inst wins.
  - Winner gets addr_ok=1 in the same cycle (zero-latency accept).
  - On that edge, latch wr/size/wstrb/addr/wdata into registers, record owner (0=inst, 1=data), go to REQ.
  - The loser sees addr_ok=0 and must hold its request.
- REQ: mem_req=1 with mem_* driven only from latched registers, so they are stable until accepted. On mem_addr_ok go to RESP. Both requester addr_ok outputs are 0.
- RESP: mem_req=0. On mem_data_ok, pulse owner's data_ok in the same cycle (combinational pass-through) and return to IDLE.
  - Writes also complete via mem_data_ok; rdata is don't-care for writes.
- Throughput: new accept no earlier than the cycle after RESP exits, so back-to-back transactions take ≥3 cycles each.
- Starvation counter (4 bits):
  - Increments on a data grant while inst_req=1, saturating at STARVE_LIMIT.
  - Cleared on any inst grant, or on a data grant with inst_req=0.
- mem_data_ok while not in RESP, or mem_addr_ok while not in REQ: ignored; no state change.
- Requester contract: req, once raised, holds with stable fields until addr_ok; requesters issue no new req before their own data_ok.

Decomposition:
- Add to mycpu.h:
  - state encodings ARB_IDLE/ARB_REQ/ARB_RESP;
  - owner encoding ARB_OWN_INST/ARB_OWN_DATA;
  - ARB_REQ_BUS_WD (wr+size+wstrb+addr+wdata = 71) for the latched request bundle.
- Single module; no sub-module. Arbitration and counter are small enough to stay inline.

Test Plan:
- Reset while in RESP with data owner -> mem_req=0, all addr_ok/data_ok=0, state IDLE.
- After reset release, inst_req alone, addr 0xBFC00000 -> inst_addr_ok same cycle; next cycle mem_req=1, mem_addr=0xBFC00000, mem_wr=0.
- Inst-read completion: mem_addr_ok, then 2 cycles later mem_data_ok with mem_rdata=0x3C1D0000 -> inst_data_ok=1 same cycle, inst_rdata=0x3C1D0000, data_data_ok=0.
- Simultaneous inst_req and data_req (sw, addr 0x80001000, wstrb 4'b1111, wdata 0x12345678) -> data_addr_ok=1, inst_addr_ok=0; mem_wr=1, mem_wdata=0x12345678.
- Stall mem_addr_ok low for 5 cycles while toggling data_addr/wdata -> mem_addr/mem_wdata stay at latched values.
- Starvation: data_req and inst_req held high, STARVE_LIMIT=4 -> 4 data grants, then 5th grant to inst, counter back to 0, 6th to data.
- Spurious mem_data_ok in IDLE -> no data_ok pulse, state unchanged.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU instruction/data memory-port arbiter.
// The request-bundle layout from MSB to LSB is {wr, size, wstrb, addr, wdata}.
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic ARB_OWN_INST = 1'b0;
  localparam logic ARB_OWN_DATA = 1'b1;

  // Bundle width at the default 32-bit address and data widths.
  localparam int ARB_REQ_BUS_WD = 71;

  function automatic int req_bus_wd(input int aw, input int dw);
    return 1 + 2 + 4 + aw + dw;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU's instruction-fetch and load/store requesters onto one sram-like
// memory port, with one transaction outstanding. Data has priority, and a starvation
// guard lets a pending fetch win.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         REQ_WD = req_bus_wd(ADDR_W, DATA_W);
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner;
  logic [3:0]        r_starve_cnt, w_starve_nxt;
  logic [REQ_WD-1:0] r_req_bus;
  logic [REQ_WD-1:0] w_inst_bus, w_data_bus;
  logic              w_grant_inst, w_grant_data, w_starved;

  assign w_inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign w_data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign w_starved  = (r_starve_cnt == LIMIT);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // Data normally wins a contested grant; a starved fetch takes this one.
        w_grant_data = data_req && !(inst_req && w_starved);
        w_grant_inst = inst_req && !w_grant_data;
        inst_addr_ok = w_grant_inst;
        data_addr_ok = w_grant_data;
        if (w_grant_inst || w_grant_data) w_state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_data_ok) begin
          inst_data_ok = (r_owner == ARB_OWN_INST);
          data_data_ok = (r_owner == ARB_OWN_DATA);
          w_state_nxt  = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant_inst) begin
      w_starve_nxt = '0;
    end else if (w_grant_data) begin
      if (!inst_req)       w_starve_nxt = '0;
      else if (!w_starved) w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_OWN_INST;
      r_starve_cnt <= '0;
      r_req_bus    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_grant_data) begin
        r_owner   <= ARB_OWN_DATA;
        r_req_bus <= w_data_bus;
      end else if (w_grant_inst) begin
        r_owner   <= ARB_OWN_INST;
        r_req_bus <= w_inst_bus;
      end
    end
  end

  // Downstream fields come only from the latched bundle so they hold while stalled.
  assign mem_wdata = r_req_bus[DATA_W-1:0];
  assign mem_addr  = r_req_bus[DATA_W +: ADDR_W];
  assign mem_wstrb = r_req_bus[DATA_W+ADDR_W +: 4];
  assign mem_size  = r_req_bus[DATA_W+ADDR_W+4 +: 2];
  assign mem_wr    = r_req_bus[REQ_WD-1];

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter: a transaction-level model predicts every
// output each cycle, and directed scenarios pin key values with literals.
module tb_cpu_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  // Model: which phase the single outstanding transaction is in
  // (0 none, 1 waiting for memory accept, 2 waiting for response).
  int          m_phase = 0;
  bit          m_own_data = 0;
  int          m_starve = 0;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  int          grants[$];

  // Requester agents: 0 idle, 1 holding req, 2 waiting for data_ok.
  int i_st = 0, d_st = 0;
  bit obs_ia, obs_da, obs_id, obs_dd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs set; returns just after the next one.
  task automatic cycle();
    bit gd, gi, exp_id, exp_dd;
    #1;
    gd = 0; gi = 0;
    if (m_phase == 0) begin
      gd = data_req && !(inst_req && m_starve == LIMIT);
      gi = inst_req && !gd;
    end
    exp_id = (m_phase == 2) && mem_data_ok && !m_own_data;
    exp_dd = (m_phase == 2) && mem_data_ok && m_own_data;
    chk("inst_addr_ok", inst_addr_ok, gi);
    chk("data_addr_ok", data_addr_ok, gd);
    chk("mem_req", mem_req, m_phase == 1);
    chk("inst_data_ok", inst_data_ok, exp_id);
    chk("data_data_ok", data_data_ok, exp_dd);
    if (m_phase == 1) begin
      chk("mem_wr", mem_wr, m_wr);
      chk("mem_size", mem_size, m_size);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (exp_id) chk("inst_rdata", inst_rdata, mem_rdata);
    if (exp_dd) chk("data_rdata", data_rdata, mem_rdata);
    obs_ia = inst_addr_ok; obs_da = data_addr_ok;
    obs_id = inst_data_ok; obs_dd = data_data_ok;
    @(posedge clk);
    case (m_phase)
      0: begin
        if (gd) begin
          {m_wr, m_size, m_wstrb, m_addr, m_wdata} = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
          m_own_data = 1;
          m_starve = inst_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
          grants.push_back(1);
          m_phase = 1;
        end else if (gi) begin
          {m_wr, m_size, m_wstrb, m_addr, m_wdata} = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
          m_own_data = 0;
          m_starve = 0;
          grants.push_back(0);
          m_phase = 1;
        end
      end
      1: if (mem_addr_ok) m_phase = 2;
      default: if (mem_data_ok) m_phase = 0;
    endcase
    if (i_st == 1 && obs_ia) i_st = 2;
    else if (i_st == 2 && obs_id) i_st = 0;
    if (d_st == 1 && obs_da) d_st = 2;
    else if (d_st == 2 && obs_dd) d_st = 0;
    @(negedge clk);
  endtask

  task automatic drive(input bit dense);
    if (i_st != 1) begin
      inst_addr  = $urandom & 32'hFFFF_FFFC;
      inst_wdata = $urandom;
      inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
      if (i_st == 0 && (dense || $urandom_range(0, 2) == 0)) i_st = 1;
    end
    if (d_st != 1) begin
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom);
      if (d_st == 0 && (dense || $urandom_range(0, 1) == 0)) d_st = 1;
    end
    inst_req = (i_st == 1);
    data_req = (d_st == 1);
    mem_addr_ok = dense ? 1'b1 : 1'($urandom_range(0, 1));
    mem_data_ok = dense ? 1'b1 : ($urandom_range(0, 2) == 0);
    mem_rdata   = $urandom;
  endtask

  // Asserted between edges with mem_data_ok high to show a late response is dropped.
  task automatic do_reset();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    reset = 1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_ctl", {mem_wr, mem_size, mem_wstrb}, 0);
    m_phase = 0; m_starve = 0; i_st = 0; d_st = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0; mem_data_ok = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Lone fetch, accepted in the same cycle, then presented downstream.
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_wstrb = 4'hF; inst_addr = 32'hBFC0_0000;
    #1 chk("t2_inst_addr_ok", inst_addr_ok, 1);
    cycle();
    inst_req = 0;
    #1;
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("t2_mem_wr", mem_wr, 0);
    cycle();
    mem_addr_ok = 1; cycle();
    mem_addr_ok = 0; cycle();
    mem_data_ok = 1; mem_rdata = 32'h3C1D_0000;
    #1;
    chk("t3_inst_data_ok", inst_data_ok, 1);
    chk("t3_inst_rdata", inst_rdata, 32'h3C1D_0000);
    chk("t3_data_data_ok", data_data_ok, 0);
    cycle();
    mem_data_ok = 0;

    // Contested grant goes to the store; its fields hold while memory stalls.
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
    #1;
    chk("t4_data_addr_ok", data_addr_ok, 1);
    chk("t4_inst_addr_ok", inst_addr_ok, 0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      data_req = 0; data_addr = $urandom; data_wdata = $urandom; data_wr = 0;
      #1;
      chk("t5_mem_addr", mem_addr, 32'h8000_1000);
      chk("t5_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("t5_mem_wr", mem_wr, 1);
      cycle();
    end
    mem_addr_ok = 1; cycle();
    mem_addr_ok = 0; mem_data_ok = 1; cycle();
    mem_data_ok = 0;

    // Get a data transaction into the response phase, then reset.
    data_req = 1; cycle();
    data_req = 0; mem_addr_ok = 1; cycle();
    mem_addr_ok = 0;
    do_reset();

    // Stray memory handshakes while idle.
    inst_req = 0; data_req = 0; mem_data_ok = 1; mem_addr_ok = 1;
    #1;
    chk("t7_inst_data_ok", inst_data_ok, 0);
    chk("t7_data_data_ok", data_data_ok, 0);
    cycle();
    mem_data_ok = 0; mem_addr_ok = 0;
    #1 chk("t7_mem_req", mem_req, 0);
    cycle();

    // Both sides always requesting: four data grants, then the fetch, then data again.
    do_reset();
    grants.delete();
    for (int n = 0; n < 80 && grants.size() < 6; n++) begin
      drive(1'b1);
      cycle();
    end
    chk("starve_grant_count", grants.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) chk($sformatf("starve_grant%0d", k), grants[k], (k == 4) ? 0 : 1);

    // Random traffic with a reset in the middle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      drive(1'b0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
